// File: rtl/desc_rot_sched.sv
// desc_rot_sched: sequences the shared rotated-coordinate ROM bank for two
// descriptor lanes. A round-robin arbiter grants one lane at a time. The
// granted lane's orientation bin is latched, and all 256 window addresses are
// swept. Each ROM x/y offset pair is registered and streamed downstream under
// valid/ready handshaking.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req[1:0]        per-lane sweep request (level, held until done)
//   ori0, ori1      per-lane orientation bin, sampled at grant
//   gnt[1:0]        one-hot current owner (SWEEP/DRAIN)
//   done[1:0]       one-cycle pulse to owner when its last sample is accepted
//   ori_err         one-cycle pulse at grant when the requested bin is illegal
//   rom_ori, rom_a  bin select and window address to the ROM bank
//   rom_x, rom_y    combinational ROM offsets for rom_ori/rom_a
//   out_*           registered sample stream (valid/ready)
module desc_rot_sched #(
    parameter int unsigned NUM_BINS = 36,
    parameter int unsigned ORI_W    = 6,
    parameter int unsigned OFS_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [ORI_W-1:0] ori0,
    input  logic [ORI_W-1:0] ori1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             ori_err,
    output logic [ORI_W-1:0] rom_ori,
    output logic [7:0]       rom_a,
    input  logic [OFS_W-1:0] rom_x,
    input  logic [OFS_W-1:0] rom_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OFS_W-1:0] out_x,
    output logic [OFS_W-1:0] out_y,
    output logic [7:0]       out_a,
    output logic             out_src,
    output logic             out_last
);

    localparam logic [ORI_W-1:0] LAST_BIN = ORI_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [ORI_W-1:0] rom_ori_q, rom_ori_d;
    logic [7:0]       rom_a_q, rom_a_d;
    logic             out_valid_q, out_valid_d;
    logic [OFS_W-1:0] out_x_q, out_x_d;
    logic [OFS_W-1:0] out_y_q, out_y_d;
    logic [7:0]       out_a_q, out_a_d;
    logic             out_src_q, out_src_d;
    logic             out_last_q, out_last_d;
    logic [1:0]       done_q, done_d;
    logic             ori_err_q, ori_err_d;

    logic             adv;
    logic             win;
    logic [ORI_W-1:0] win_ori;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        rom_ori_d   = rom_ori_q;
        rom_a_d     = rom_a_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_a_d     = out_a_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        done_d      = '0;
        ori_err_d   = 1'b0;

        adv     = !out_valid_q || out_ready;
        // Sole requester wins; on contention the rr pointer decides.
        win     = (req == 2'b11) ? rr_q : req[1];
        win_ori = win ? ori1 : ori0;

        unique case (state_q)
            S_IDLE: begin
                // The done cycle is skipped so the next grant lands one cycle later.
                if (!done_q[0] && !done_q[1] && (req != 2'b00)) begin
                    state_d = S_SWEEP;
                    owner_d = win;
                    rom_a_d = '0;
                    if (win_ori > LAST_BIN) begin
                        rom_ori_d = LAST_BIN;
                        ori_err_d = 1'b1;
                    end else begin
                        rom_ori_d = win_ori;
                    end
                end
            end
            S_SWEEP: begin
                if (adv) begin
                    out_valid_d = 1'b1;
                    out_x_d     = rom_x;
                    out_y_d     = rom_y;
                    out_a_d     = rom_a_q;
                    out_src_d   = owner_q;
                    out_last_d  = (rom_a_q == 8'hff);
                    if (rom_a_q == 8'hff) begin
                        state_d = S_DRAIN;
                    end else begin
                        rom_a_d = rom_a_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = owner_q ? 2'b10 : 2'b01;
                    rr_d        = ~owner_q;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            rom_ori_q   <= '0;
            rom_a_q     <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_a_q     <= '0;
            out_src_q   <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= '0;
            ori_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            rom_ori_q   <= rom_ori_d;
            rom_a_q     <= rom_a_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_a_q     <= out_a_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            ori_err_q   <= ori_err_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q != S_IDLE) begin
            gnt = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign done      = done_q;
    assign ori_err   = ori_err_q;
    assign rom_ori   = rom_ori_q;
    assign rom_a     = rom_a_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_a     = out_a_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_desc_rot_sched.sv
// Testbench for desc_rot_sched. It uses a behavioural ROM bank and a
// per-sweep reference model (expected address sequence, owner, bin, and
// done/grant timing) under random downstream backpressure.
module tb_desc_rot_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [5:0] ori0, ori1;
    logic [1:0] gnt, done;
    logic       ori_err;
    logic [5:0] rom_ori;
    logic [7:0] rom_a;
    logic [4:0] rom_x, rom_y;
    logic       out_valid, out_ready;
    logic [4:0] out_x, out_y;
    logic [7:0] out_a;
    logic       out_src, out_last;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    always #5 clk = ~clk;

    desc_rot_sched #(.NUM_BINS(36), .ORI_W(6), .OFS_W(5)) dut (
        .clk(clk), .rst(rst), .req(req), .ori0(ori0), .ori1(ori1),
        .gnt(gnt), .done(done), .ori_err(ori_err),
        .rom_ori(rom_ori), .rom_a(rom_a), .rom_x(rom_x), .rom_y(rom_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_a(out_a),
        .out_src(out_src), .out_last(out_last)
    );

    // Behavioural ROM bank: an arbitrary per-bin pattern, with bin 29 pinned
    // at a few reference points.
    function automatic logic [4:0] rom_fx(input int b, input int a);
        int v;
        v = (a % 16) * 3 + (a / 16) + b * 11;
        return v[4:0];
    endfunction

    function automatic logic [4:0] rom_fy(input int b, input int a);
        int v;
        v = ((a * 5) + (b * 7)) ^ (a / 16);
        if (b == 29 && a == 0)   v = 5;
        if (b == 29 && a == 96)  v = -1;
        if (b == 29 && a == 255) v = -4;
        return v[4:0];
    endfunction

    always_comb begin
        rom_x = rom_fx(int'(rom_ori), int'(rom_a));
        rom_y = rom_fy(int'(rom_ori), int'(rom_a));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] onehot(input int lane);
        return (lane == 1) ? 2'b10 : 2'b01;
    endfunction

    // Wait up to 'limit' negedges for a grant, then check the grant-cycle view.
    task automatic wait_grant(input int lane, input int bin, input logic err, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) break;
        end
        chk("grant_seen", 32'(gnt != 2'b00), 32'd1);
        chk("gnt", 32'(gnt), 32'(onehot(lane)));
        chk("rom_ori_at_grant", 32'(rom_ori), 32'(bin));
        chk("ori_err_at_grant", 32'(ori_err), 32'(err));
        chk("rom_a_at_grant", 32'(rom_a), 32'd0);
        chk("valid_at_grant", 32'(out_valid), 32'd0);
    endtask

    // Follow one sweep from the grant cycle. stall_pct: chance out_ready is low.
    // abort_at >= 0: pulse rst once that many beats are accepted.
    // drop_at >= 0: the owner drops req after that many beats.
    task automatic sweep(input int lane, input int bin, input int stall_pct,
                         input int abort_at, input int drop_at);
        int         idx = 0;
        int         cycles = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] p_a = '0, p_rom_a = '0;
        logic [4:0] p_x = '0, p_y = '0;
        logic       p_last = 1'b0;
        while (idx < 256 && cycles < 4000) begin
            cycles++;
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 99) >= stall_pct);
            @(negedge clk);
            // Changing the owner's ori mid-sweep must not matter.
            if (lane == 0) ori0 = 6'($urandom); else ori1 = 6'($urandom);
            chk("gnt_held", 32'(gnt), 32'(onehot(lane)));
            chk("rom_ori_held", 32'(rom_ori), 32'(bin));
            chk("ori_err_quiet", 32'(ori_err), 32'd0);
            chk("done_quiet", 32'(done), 32'd0);
            if (prev_stall) begin
                chk("hold_a", 32'(out_a), 32'(p_a));
                chk("hold_x", 32'(out_x), 32'(p_x));
                chk("hold_y", 32'(out_y), 32'(p_y));
                chk("hold_last", 32'(out_last), 32'(p_last));
                chk("hold_rom_a", 32'(rom_a), 32'(p_rom_a));
            end
            if (out_valid) begin
                chk("out_a", 32'(out_a), 32'(idx));
                chk("out_x", 32'(out_x), 32'(rom_fx(bin, idx)));
                chk("out_y", 32'(out_y), 32'(rom_fy(bin, idx)));
                chk("out_src", 32'(out_src), 32'(lane));
                chk("out_last", 32'(out_last), 32'(idx == 255));
                if (bin == 29 && idx == 0)   chk("y_bin29_a0", 32'(out_y), 32'h05);
                if (bin == 29 && idx == 96)  chk("y_bin29_a96", 32'(out_y), 32'h1f);
                if (bin == 29 && idx == 255) chk("y_bin29_a255", 32'(out_y), 32'h1c);
            end
            prev_stall = out_valid && !out_ready;
            p_a = out_a; p_x = out_x; p_y = out_y; p_last = out_last; p_rom_a = rom_a;
            if (out_valid && out_ready) idx++;
            if (drop_at >= 0 && idx == drop_at) req[lane] = 1'b0;
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_gnt", 32'(gnt), 32'd0);
                chk("abort_rom_a", 32'(rom_a), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                rst = 1'b0;
                out_ready = 1'b1;
                return;
            end
        end
        chk("sweep_in_budget", 32'(idx), 32'd256);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(onehot(lane)));
        chk("gnt_released", 32'(gnt), 32'd0);
        chk("valid_after_done", 32'(out_valid), 32'd0);
        req[lane] = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("no_grant_in_done_cycle", 32'(gnt), 32'd0);
    endtask

    initial begin
        int b;
        rst = 1'b1; req = '0; ori0 = '0; ori1 = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(ori_err), 32'd0);
        chk("rst_rom_ori", 32'(rom_ori), 32'd0);
        chk("rst_rom_a", 32'(rom_a), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'({out_x, out_y, out_a, out_src, out_last}), 32'd0);
        rst = 1'b0;

        // Lane 0 alone, bin 29, no backpressure.
        ori0 = 6'd29; req = 2'b01;
        wait_grant(0, 29, 1'b0, 1);
        sweep(0, 29, 0, -1, -1);

        // Both lanes from reset: lane 0 first, lane 1 two cycles after done.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ori0 = 6'd3; ori1 = 6'd7; req = 2'b11;
        wait_grant(0, 3, 1'b0, 1);
        sweep(0, 3, 40, -1, -1);
        wait_grant(1, 7, 1'b0, 1);
        sweep(1, 7, 30, -1, -1);

        // Out-of-range bin clamps to 35 with an error pulse.
        ori1 = 6'd40; req = 2'b10;
        wait_grant(1, 35, 1'b1, 3);
        sweep(1, 35, 25, -1, -1);

        // Reset mid-sweep, then restart from address 0.
        b = int'($urandom_range(0, 35));
        ori1 = 6'(b); req = 2'b10;
        wait_grant(1, b, 1'b0, 3);
        sweep(1, b, 20, 100, -1);
        ori1 = 6'(b);
        wait_grant(1, b, 1'b0, 2);
        sweep(1, b, 0, -1, -1);

        // Lane 0 drops req mid-sweep; the sweep still completes.
        b = int'($urandom_range(0, 35));
        ori0 = 6'(b); req = 2'b01;
        wait_grant(0, b, 1'b0, 3);
        sweep(0, b, 15, -1, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
